// File: rtl/memory_island_pkg.sv
// Shared types and width helpers for the memory island bank arbiter.
// Contents:
//   resp_tag_t        - in-flight response tag {valid, is_wide, narrow_idx}
//   NarrowIdxWidth    - width of a narrow requester index (supports up to MaxNarrow)
//   starve_cnt_width  - width of the starvation counter for a given WidePriorityWait
package memory_island_pkg;

    localparam int unsigned MaxNarrow      = 16;
    localparam int unsigned NarrowIdxWidth = $clog2(MaxNarrow);

    typedef struct packed {
        logic                      valid;
        logic                      is_wide;
        logic [NarrowIdxWidth-1:0] narrow_idx;
    } resp_tag_t;

    // $clog2(wait+1), kept at least 1 bit so the counter is always declarable.
    function automatic int unsigned starve_cnt_width(input int unsigned wide_prio_wait);
        return (wide_prio_wait == 0) ? 1 : $clog2(wide_prio_wait + 1);
    endfunction

endpackage

// File: rtl/memory_island_rr_sel.sv
// Round-robin selector over the narrow requesters.
// Ports:
//   clk_i, rst_ni  - clock, async active-low reset
//   req_i          - narrow request vector
//   advance_i      - selected narrow requester was granted this cycle
//   sel_o          - one-hot select (combinational), zero when no request
//   idx_o          - index of the selected requester (combinational)
module memory_island_rr_sel
    import memory_island_pkg::*;
#(
    parameter int unsigned NumNarrow = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumNarrow-1:0]      req_i,
    input  logic                      advance_i,
    output logic [NumNarrow-1:0]      sel_o,
    output logic [NarrowIdxWidth-1:0] idx_o
);

    logic [NarrowIdxWidth-1:0] rr_ptr_q, rr_ptr_d;

    // First requester at or after the pointer, else the lowest requester (wrap).
    always_comb begin : select
        logic found;
        found = 1'b0;
        sel_o = '0;
        idx_o = '0;
        for (int unsigned i = 0; i < NumNarrow; i++) begin
            if (!found && req_i[i] && (i >= 32'(rr_ptr_q))) begin
                found    = 1'b1;
                sel_o[i] = 1'b1;
                idx_o    = NarrowIdxWidth'(i);
            end
        end
        for (int unsigned i = 0; i < NumNarrow; i++) begin
            if (!found && req_i[i]) begin
                found    = 1'b1;
                sel_o[i] = 1'b1;
                idx_o    = NarrowIdxWidth'(i);
            end
        end
    end

    // Pointer moves just past the granted index.
    always_comb begin : ptr_next
        rr_ptr_d = rr_ptr_q;
        if (advance_i) begin
            rr_ptr_d = ((32'(idx_o) + 32'd1) >= NumNarrow) ? '0
                                                         : NarrowIdxWidth'(32'(idx_o) + 32'd1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/memory_island_bank_arbiter.sv
// Per-bank arbiter: shares one single-ported SRAM bank between NumNarrow
// narrow requesters and one wide requester (req/gnt/rvalid protocol).
// Wide wins by default; after WidePriorityWait consecutive wide wins with
// narrow waiting, narrow wins once. Narrow sources are served round-robin.
// Ports:
//   clk_i, rst_ni          - clock, async active-low reset
//   narrow_*_i / _o        - narrow request fields, grants, rvalids, shared rdata
//   wide_*_i / _o          - wide request fields, grant, rvalid, rdata
//   bank_*_o, bank_rdata_i - SRAM bank interface (read data BankLatency cycles after req)
//   starve_events_o        - only with MEMORY_ISLAND_ARB_PERF_EN: count of cycles in
//                            which narrow priority overrode a pending wide request
module memory_island_bank_arbiter
    import memory_island_pkg::*;
#(
    parameter  int unsigned NumNarrow        = 2,
    parameter  int unsigned AddrWidth        = 12,
    parameter  int unsigned DataWidth        = 32,
    parameter  int unsigned BankLatency      = 1,
    parameter  int unsigned WidePriorityWait = 1,
    localparam int unsigned StrbWidth        = DataWidth / 8
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumNarrow-1:0]                narrow_req_i,
    output logic [NumNarrow-1:0]                narrow_gnt_o,
    input  logic [NumNarrow-1:0][AddrWidth-1:0] narrow_addr_i,
    input  logic [NumNarrow-1:0]                narrow_we_i,
    input  logic [NumNarrow-1:0][DataWidth-1:0] narrow_wdata_i,
    input  logic [NumNarrow-1:0][StrbWidth-1:0] narrow_strb_i,
    output logic [NumNarrow-1:0]                narrow_rvalid_o,
    output logic [DataWidth-1:0]                narrow_rdata_o,
    input  logic                                wide_req_i,
    output logic                                wide_gnt_o,
    input  logic [AddrWidth-1:0]                wide_addr_i,
    input  logic                                wide_we_i,
    input  logic [DataWidth-1:0]                wide_wdata_i,
    input  logic [StrbWidth-1:0]                wide_strb_i,
    output logic                                wide_rvalid_o,
    output logic [DataWidth-1:0]                wide_rdata_o,
    output logic                                bank_req_o,
    output logic                                bank_we_o,
    output logic [AddrWidth-1:0]                bank_addr_o,
    output logic [DataWidth-1:0]                bank_wdata_o,
    output logic [StrbWidth-1:0]                bank_strb_o,
    input  logic [DataWidth-1:0]                bank_rdata_i
`ifdef MEMORY_ISLAND_ARB_PERF_EN
    ,
    output logic [31:0]                         starve_events_o
`endif
);

    localparam int unsigned          CntWidth = starve_cnt_width(WidePriorityWait);
    localparam logic [CntWidth-1:0]  WaitThr  = CntWidth'(WidePriorityWait);
    localparam logic [CntWidth-1:0]  CntMax   = '1;

    logic                      narrow_any;
    logic                      narrow_prio;
    logic                      wide_win;
    logic                      narrow_win;
    logic [NumNarrow-1:0]      rr_sel;
    logic [NarrowIdxWidth-1:0] rr_idx;
    logic [CntWidth-1:0]       starve_cnt_q, starve_cnt_d;
    resp_tag_t                 pipe_q [BankLatency];
    resp_tag_t                 pipe_d [BankLatency];
    resp_tag_t                 tail;

    memory_island_rr_sel #(
        .NumNarrow (NumNarrow)
    ) u_rr_sel (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (narrow_req_i),
        .advance_i (narrow_win),
        .sel_o     (rr_sel),
        .idx_o     (rr_idx)
    );

    // Winner selection: wide unless narrow has earned priority and is waiting.
    assign narrow_any   = |narrow_req_i;
    assign narrow_prio  = (WidePriorityWait != 0) && (starve_cnt_q >= WaitThr);
    assign wide_win     = wide_req_i && (!narrow_prio || !narrow_any);
    assign narrow_win   = narrow_any && !wide_win;
    assign wide_gnt_o   = wide_win;
    assign narrow_gnt_o = narrow_win ? rr_sel : '0;
    assign bank_req_o   = wide_win || narrow_win;

    // Bank request fields from the winner.
    always_comb begin : bank_mux
        bank_we_o    = 1'b0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        bank_strb_o  = '0;
        if (wide_win) begin
            bank_we_o    = wide_we_i;
            bank_addr_o  = wide_addr_i;
            bank_wdata_o = wide_wdata_i;
            bank_strb_o  = wide_strb_i;
        end else if (narrow_win) begin
            for (int unsigned i = 0; i < NumNarrow; i++) begin
                if (rr_sel[i]) begin
                    bank_we_o    = narrow_we_i[i];
                    bank_addr_o  = narrow_addr_i[i];
                    bank_wdata_o = narrow_wdata_i[i];
                    bank_strb_o  = narrow_strb_i[i];
                end
            end
        end
    end

    // Saturating count of wide wins while narrow waits; any other cycle clears it.
    always_comb begin : starve_next
        starve_cnt_d = '0;
        if (wide_win && narrow_any) begin
            starve_cnt_d = (starve_cnt_q == CntMax) ? starve_cnt_q
                                                    : starve_cnt_q + CntWidth'(1);
        end
    end

    // Response tag pipeline matching the bank latency.
    always_comb begin : pipe_next
        pipe_d[0].valid      = bank_req_o;
        pipe_d[0].is_wide    = wide_win;
        pipe_d[0].narrow_idx = narrow_win ? rr_idx : '0;
        for (int unsigned s = 1; s < BankLatency; s++) begin
            pipe_d[s] = pipe_q[s-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= '0;
            for (int unsigned s = 0; s < BankLatency; s++) begin
                pipe_q[s] <= '0;
            end
        end else begin
            starve_cnt_q <= starve_cnt_d;
            pipe_q       <= pipe_d;
        end
    end

    // Route the tail tag to its source; rdata is broadcast.
    assign tail           = pipe_q[BankLatency-1];
    assign wide_rvalid_o  = tail.valid && tail.is_wide;
    assign wide_rdata_o   = bank_rdata_i;
    assign narrow_rdata_o = bank_rdata_i;

    always_comb begin : rvalid_decode
        narrow_rvalid_o = '0;
        for (int unsigned i = 0; i < NumNarrow; i++) begin
            narrow_rvalid_o[i] = tail.valid && !tail.is_wide
                                 && (tail.narrow_idx == NarrowIdxWidth'(i));
        end
    end

`ifdef MEMORY_ISLAND_ARB_PERF_EN
    logic [31:0] starve_events_q, starve_events_d;

    // Wrapping count of cycles where narrow priority displaced a wide request.
    always_comb begin : perf_next
        starve_events_d = starve_events_q;
        if (wide_req_i && narrow_any && narrow_prio) begin
            starve_events_d = starve_events_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_events_q <= '0;
        end else begin
            starve_events_q <= starve_events_d;
        end
    end

    assign starve_events_o = starve_events_q;
`endif

endmodule

// File: tb/tb_memory_island_bank_arbiter.sv
// Scoreboard bench for memory_island_bank_arbiter (NumNarrow=2, BankLatency=2,
// WidePriorityWait=2). Stimulus computes the expected winner/response from the
// arbitration rules and queues it; a negedge monitor pops and compares.
module tb_memory_island_bank_arbiter;

    localparam int unsigned NN  = 2;
    localparam int unsigned AW  = 12;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = DW / 8;
    localparam int unsigned LAT = 2;
    localparam int unsigned WPW = 2;

    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [NN-1:0]         narrow_req, narrow_gnt, narrow_we, narrow_rvalid;
    logic [NN-1:0][AW-1:0] narrow_addr;
    logic [NN-1:0][DW-1:0] narrow_wdata;
    logic [NN-1:0][SW-1:0] narrow_strb;
    logic [DW-1:0]         narrow_rdata;
    logic                  wide_req, wide_gnt, wide_we, wide_rvalid;
    logic [AW-1:0]         wide_addr;
    logic [DW-1:0]         wide_wdata, wide_rdata;
    logic [SW-1:0]         wide_strb;
    logic                  bank_req, bank_we;
    logic [AW-1:0]         bank_addr;
    logic [DW-1:0]         bank_wdata, bank_rdata;
    logic [SW-1:0]         bank_strb;
`ifdef MEMORY_ISLAND_ARB_PERF_EN
    logic [31:0]           starve_events;
`endif

    memory_island_bank_arbiter #(
        .NumNarrow        (NN),
        .AddrWidth        (AW),
        .DataWidth        (DW),
        .BankLatency      (LAT),
        .WidePriorityWait (WPW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .narrow_req_i    (narrow_req),
        .narrow_gnt_o    (narrow_gnt),
        .narrow_addr_i   (narrow_addr),
        .narrow_we_i     (narrow_we),
        .narrow_wdata_i  (narrow_wdata),
        .narrow_strb_i   (narrow_strb),
        .narrow_rvalid_o (narrow_rvalid),
        .narrow_rdata_o  (narrow_rdata),
        .wide_req_i      (wide_req),
        .wide_gnt_o      (wide_gnt),
        .wide_addr_i     (wide_addr),
        .wide_we_i       (wide_we),
        .wide_wdata_i    (wide_wdata),
        .wide_strb_i     (wide_strb),
        .wide_rvalid_o   (wide_rvalid),
        .wide_rdata_o    (wide_rdata),
        .bank_req_o      (bank_req),
        .bank_we_o       (bank_we),
        .bank_addr_o     (bank_addr),
        .bank_wdata_o    (bank_wdata),
        .bank_strb_o     (bank_strb),
        .bank_rdata_i    (bank_rdata)
`ifdef MEMORY_ISLAND_ARB_PERF_EN
        ,
        .starve_events_o (starve_events)
`endif
    );

    function automatic logic [DW-1:0] init_word(input int a);
        return (a == 16) ? 32'hDEAD_BEEF : (32'h1000_0000 + 32'(a) * 32'h0101_0101);
    endfunction

    // Bench-side SRAM bank: reloads during reset, read latency LAT.
    logic [DW-1:0] mem     [32];
    logic [DW-1:0] rd_pipe [LAT];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int a = 0; a < 32; a++) mem[a] <= init_word(a);
        end else if (bank_req) begin
            if (bank_we) begin
                for (int b = 0; b < int'(SW); b++)
                    if (bank_strb[b]) mem[bank_addr[4:0]][b*8 +: 8] <= bank_wdata[b*8 +: 8];
            end
            rd_pipe[0] <= mem[bank_addr[4:0]];
        end
        for (int s = 1; s < int'(LAT); s++) rd_pipe[s] <= rd_pipe[s-1];
    end
    assign bank_rdata = rd_pipe[LAT-1];

    typedef struct {
        logic [NN-1:0] ngnt;
        logic          wgnt;
        logic          breq;
        logic          bwe;
        logic [AW-1:0] baddr;
        logic [DW-1:0] bwdata;
        logic [SW-1:0] bstrb;
    } gnt_exp_t;

    typedef struct {
        int            due;
        logic          is_wide;
        int            idx;
        logic          is_read;
        logic [DW-1:0] data;
    } resp_exp_t;

    gnt_exp_t      gnt_q [$];
    resp_exp_t     resp_q[$];
    logic [DW-1:0] ref_mem[32];
    int            streak;
    int            rr_start;
    int            cyc;
    int            checks;
    int            errors;
    bit            mon_en;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [127:0] act,
                                  input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        streak   = 0;
        rr_start = 0;
        resp_q.delete();
        for (int a = 0; a < 32; a++) ref_mem[a] = init_word(a);
    endfunction

    task automatic rand_fields();
        for (int i = 0; i < int'(NN); i++) begin
            narrow_addr[i]  = AW'($urandom_range(15));
            narrow_we[i]    = 1'($urandom_range(1));
            narrow_wdata[i] = $urandom;
            narrow_strb[i]  = SW'($urandom_range(15));
        end
        wide_addr  = AW'($urandom_range(15));
        wide_we    = 1'($urandom_range(1));
        wide_wdata = $urandom;
        wide_strb  = SW'($urandom_range(15));
    endtask

    // Reference arbitration for the current inputs, then advance one cycle.
    task automatic step();
        gnt_exp_t  g;
        resp_exp_t r;
        bit        n_any, prio;
        int        win;
        logic      we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [SW-1:0] st;
        g     = '{default: '0};
        r     = '{default: '0};
        n_any = |narrow_req;
        prio  = (WPW != 0) && (streak >= int'(WPW));
        win   = -1;
        if (wide_req && (!prio || !n_any)) begin
            win = int'(NN);
        end else if (n_any) begin
            for (int k = 0; k < int'(NN); k++) begin
                int idx;
                idx = (rr_start + k) % int'(NN);
                if (win < 0 && narrow_req[idx]) win = idx;
            end
        end
        if (win == int'(NN)) begin
            streak = n_any ? streak + 1 : 0;
            g.wgnt = 1'b1;
            we = wide_we; addr = wide_addr; wd = wide_wdata; st = wide_strb;
        end else begin
            streak = 0;
            if (win >= 0) begin
                g.ngnt[win] = 1'b1;
                rr_start    = (win + 1) % int'(NN);
                we = narrow_we[win]; addr = narrow_addr[win];
                wd = narrow_wdata[win]; st = narrow_strb[win];
            end
        end
        if (win >= 0) begin
            g.breq    = 1'b1;
            g.bwe     = we;
            g.baddr   = addr;
            g.bwdata  = wd;
            g.bstrb   = st;
            r.due     = cyc + int'(LAT);
            r.is_wide = (win == int'(NN));
            r.idx     = win;
            r.is_read = !we;
            if (!we) r.data = ref_mem[addr[4:0]];
            else
                for (int b = 0; b < int'(SW); b++)
                    if (st[b]) ref_mem[addr[4:0]][b*8 +: 8] = wd[b*8 +: 8];
            resp_q.push_back(r);
        end
        gnt_q.push_back(g);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        narrow_req = '0;
        wide_req   = 1'b0;
        repeat (n) step();
    endtask

    // Monitor: compares grants/bank fields every cycle and responses when due.
    gnt_exp_t       mg;
    resp_exp_t      mr;
    logic [NN:0]    exp_rv;
    bit             have;
    always @(negedge clk) begin
        if (mon_en) begin
            if (gnt_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL gnt_queue: got empty expected entry (cycle %0d)", cyc);
            end else begin
                mg = gnt_q.pop_front();
                check("grant", {narrow_gnt, wide_gnt, bank_req}, {mg.ngnt, mg.wgnt, mg.breq});
                if (mg.breq)
                    check("bank_fields",
                          {bank_we, bank_addr, mg.bwe ? bank_wdata : '0, mg.bwe ? bank_strb : '0},
                          {mg.bwe, mg.baddr, mg.bwe ? mg.bwdata : '0, mg.bwe ? mg.bstrb : '0});
            end
            have   = 1'b0;
            exp_rv = '0;
            if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
                mr   = resp_q.pop_front();
                have = 1'b1;
                if (mr.is_wide) exp_rv[NN] = 1'b1;
                else            exp_rv[mr.idx] = 1'b1;
            end
            check("rvalid", {wide_rvalid, narrow_rvalid}, exp_rv);
            if (have && mr.is_read)
                check("rdata", mr.is_wide ? wide_rdata : narrow_rdata, mr.data);
        end
    end

    initial begin
        rst_n        = 1'b0;
        narrow_req   = '0;
        narrow_addr  = '0;
        narrow_we    = '0;
        narrow_wdata = '0;
        narrow_strb  = '0;
        wide_req     = 1'b0;
        wide_addr    = '0;
        wide_we      = 1'b0;
        wide_wdata   = '0;
        wide_strb    = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Narrow-only round robin.
        narrow_req = 2'b11;
        repeat (4) begin rand_fields(); step(); end
        idle(1);

        // Continuous contention: W, W, N0, W, W, N1.
        narrow_req = 2'b11;
        wide_req   = 1'b1;
        repeat (6) begin rand_fields(); step(); end
        idle(3);

        // Narrow 1 reads 0x010 (preloaded 0xDEADBEEF).
        narrow_req     = 2'b10;
        narrow_addr[1] = 12'h010;
        narrow_we[1]   = 1'b0;
        step();
        idle(3);

        // Reset one cycle after a grant: its response must never appear.
        narrow_req     = 2'b01;
        narrow_we[0]   = 1'b0;
        narrow_addr[0] = 12'h003;
        step();
        narrow_req = '0;
        rst_n      = 1'b0;
        model_reset();
        idle(2);
        rst_n = 1'b1;
        idle(4);

        // Random traffic.
        repeat (400) begin
            rand_fields();
            narrow_req = NN'($urandom_range(3));
            wide_req   = 1'($urandom_range(1));
            step();
        end
        idle(int'(LAT) + 2);

        checks++;
        if (resp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending responses expected 0", resp_q.size());
        end
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
